// File: rtl/alu_result_buf.sv
// ---------------------------------------------------------------------------
// alu_result_buf
//
// Flow-controlled holding buffer for ALU results in the multi-cycle RV32I
// datapath. It is a DEPTH-entry FIFO of WIDTH-bit results. A "last result"
// register always holds the most recently accepted value, so results
// survive multi-cycle stalls in the writeback/memory-address consumers.
//
// Handshake: a beat transfers on a rising edge where valid and ready are
// both 1 (and flush is 0). The producer holds in_data stable while
// in_valid=1 and in_ready=0. in_ready is derived from registered
// occupancy only and never looks at out_ready or flush.
//
// Optional feature macro: ALU_BUF_BYPASS_EN
//   defined   - when the buffer is empty, an incoming beat is presented
//               on out_valid/out_data in the same cycle. If the consumer
//               takes it, the beat is never stored.
//   undefined - there is no combinational input-to-output path. out_valid
//               depends only on registered state.
//
// Parameters
//   WIDTH      data width in bits (>= 1)
//   DEPTH      number of entries (power of two, >= 2)
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   flush      synchronous discard of all buffered entries
//   in_valid   producer has a result on in_data
//   in_data    ALU result
//   in_ready   buffer can accept (count < DEPTH)
//   out_valid  out_data holds the oldest entry
//   out_data   oldest entry (head)
//   out_ready  consumer takes the head this cycle
//   count      number of stored entries, 0..DEPTH
//   last_data  most recently accepted in_data
// ---------------------------------------------------------------------------
module alu_result_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           last_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Occupancy is decoded from count rather than kept as separate state.
    // This way it can never disagree with the counter.
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    occ_t             occ;

    logic             bypass;
    logic             accept;
    logic             push;
    logic             pop;

    always_comb begin
        occ = OCC_PARTIAL;
        if (count == '0) begin
            occ = OCC_EMPTY;
        end else if (count == CW'(DEPTH)) begin
            occ = OCC_FULL;
        end
    end

    assign in_ready = (occ != OCC_FULL);

`ifdef ALU_BUF_BYPASS_EN
    // An empty buffer forwards the incoming beat straight to the consumer.
    assign bypass = (occ == OCC_EMPTY) & in_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = (occ != OCC_EMPTY) | bypass;
    assign out_data  = bypass ? in_data : mem[rp];

    // accept: the beat is taken from the producer, so last_data updates.
    // push:   the beat also lands in storage. The only case where an
    //         accepted beat is not stored is a bypass the consumer takes
    //         in the same cycle.
    assign accept = in_valid & in_ready & ~flush;
    assign push   = accept & ~(bypass & out_ready);
    // Only stored entries are popped. A bypassed beat never reaches rp.
    assign pop    = (occ != OCC_EMPTY) & out_ready & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            last_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Flush wins over push and pop. Stale memory contents are
            // harmless because out_valid is 0 until the next push.
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wp] <= in_data;
                wp      <= wp + AW'(1);
            end
            if (accept) begin
                last_data <= in_data;
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/alu_result_buf.md
# alu_result_buf

Parametrised, flow-controlled holding buffer for ALU results in the multi-cycle RV32I datapath. It generalises the single ALU-output register into a DEPTH-entry FIFO of WIDTH-bit results with valid/ready handshakes and synchronous flush. It also keeps a "last result" register that always holds the most recently accepted value. It sits between the ALU and the writeback/memory-address consumers, so results survive multi-cycle stalls without being overwritten.

## Interface
- WIDTH, 32, data width in bits (≥1).
- DEPTH, 4, number of entries; power of two, ≥2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  producer has a result on in_data.
- in_data  in  WIDTH  ALU result.
- in_ready  out  1  buffer can accept; equals (count < DEPTH), registered-state only, never depends on out_ready or flush.
- out_valid  out  1  out_data holds the oldest entry.
- out_data  out  WIDTH  oldest entry (head).
- out_ready  in  1  consumer takes the head this cycle.
- count  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- last_data  out  WIDTH  most recently accepted in_data, held until the next accept.

## Operation
- Storage: DEPTH×WIDTH array, write pointer wp, read pointer rp, each $clog2(DEPTH) bits, wrapping modulo DEPTH (natural overflow); count tracks occupancy.
- push = in_valid & in_ready & !flush. On push: mem[wp] <= in_data, wp <= wp+1, last_data <= in_data.
- pop = out_valid & out_ready & !flush. On pop: rp <= rp+1.
- count next = count + push − pop. Simultaneous push and pop leaves count unchanged.
- out_valid = (count != 0). out_data = mem[rp], and is 0 after reset until the first write.
- Occupancy states, decoded from count:
  - EMPTY (0): out_valid=0, in_ready=1.
  - PARTIAL (1..DEPTH−1): both 1.
  - FULL (DEPTH): in_ready=0, so in_valid is ignored even if out_ready=1 that cycle.
- Flush has priority over push and pop: wp, rp, and count go to 0 on the next edge. The accompanying in_data is dropped, and last_data is not updated.
- Producer rule: in_data must stay stable while in_valid=1 and in_ready=0. The block does not check this.
- out_valid to out_data remains stable until popped or flushed.

## Timing
- Reset (rst=1, asynchronous): count=0, wp=rp=0, all mem entries=0, last_data=0. Outputs are then out_valid=0, out_data=0, in_ready=1.
- Reset asserted mid-operation discards all contents immediately. The first edge after deassertion behaves as EMPTY.
- Latency without bypass: a push at edge N makes out_valid=1 and out_data valid after edge N. Head is visible in the cycle following acceptance.
- last_data updates on the same edge as the push (1-cycle latency, like a plain output register).
- Throughput: one push and one pop per cycle in PARTIAL. A full buffer accepts again the cycle after a pop.
- Wrap-around: after DEPTH pushes wp returns to 0, and ordering is preserved across the wrap.

## Configuration
- ALU_BUF_BYPASS_EN defined: when count==0 and in_valid=1 (no flush), out_valid=1 and out_data=in_data combinationally.
  - If out_ready=1 that cycle, the beat is consumed without being stored: count stays 0, wp and rp unchanged, last_data still updated.
  - If out_ready=0, the beat is stored normally.
  - Zero-cycle latency when empty.
- Not defined: no combinational in-to-out path. Minimum latency is 1 cycle, out_valid depends only on registered state.

## Test plan
- Reset check: assert rst mid-stream with count=3 → same cycle count=0, out_valid=0, out_data=0, last_data=0, in_ready=1.
- Ordering and wrap (DEPTH=4): push 0x11,0x22,0x33,0x44, with out_ready=0 → count=4, in_ready=0, and in_valid with 0x55 is ignored. Then pop all → out_data sequence 0x11,0x22,0x33,0x44, then out_valid=0. Push 6 more values and drain → correct order across the wrap.
- Simultaneous push/pop at count=2, in_data=0xDEADBEEF → count stays 2, head advances, and 0xDEADBEEF emerges after the two older entries. last_data=0xDEADBEEF.
- Full with out_ready=1 and in_valid=1 → exactly one pop, no push, count=3. The next cycle push is accepted.
- Flush at count=3 with in_valid=1, in_data=0xAAAA0000 → next cycle count=0, out_valid=0, last_data unchanged.
- Empty push of 0x1234 with out_ready=1:
  - without ALU_BUF_BYPASS_EN → out_valid rises the next cycle.
  - with ALU_BUF_BYPASS_EN → out_valid=1 and out_data=0x1234 the same cycle, count remains 0.
